// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM states and nibble geometry.
// No logic; imported by the top level.
package nibble_serial_adder_pkg;

  localparam int NIBW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must stay at least one bit wide even for a single-nibble operand.
  function automatic int idx_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/CLA_4_bit.sv
// 4-bit carry-lookahead adder; purely combinational, no flow control.
module CLA_4_bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder, one nibble per clock; result valid NIB edges after accept.
// Accepts only in IDLE; holds the result in DONE until out_ready, then returns to IDLE.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB  = WIDTH / NIBW;
  localparam int IDXW = idx_width(NIB);
  localparam int MSB  = WIDTH - 1;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [NIBW-1:0]   nib_a;
  logic [NIBW-1:0]   nib_b;
  logic [NIBW-1:0]   nib_sum;
  logic              nib_cout;
  logic              last_step;

  assign last_step = (idx_q == IDXW'(NIB - 1));

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a = a_q[i*NIBW +: NIBW];
        nib_b = b_q[i*NIBW +: NIBW];
      end
    end
  end

  CLA_4_bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx_q == IDXW'(i)) sum_d[i*NIBW +: NIBW] = nib_sum;
      end
      carry_d = nib_cout;
      idx_d   = idx_q + IDXW'(1);
      // Sign overflow needs the fully assembled sum, so it is resolved on the final step.
      if (last_step) begin
        cout_d = nib_cout;
        ovf_d  = (a_q[MSB] == b_q[MSB]) && (sum_d[MSB] != a_q[MSB]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] full;
    exp_t e;
    full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    e.s = full[15:0];
    e.c = full[16];
    e.o = (x[15] == y[15]) && (full[15] != x[15]);
    return e;
  endfunction

  // Present one operand set and let the next rising edge take it.
  task automatic drive_accept(input logic [15:0] x, input logic [15:0] y, input logic ci);
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    a = x; b = y; cin = ci; in_valid = 1'b1;
    sb.push_back(model(x, y, ci));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_taken: in_ready=%b required 0", in_ready);
    end
  endtask

  // Called right after the accepting edge; checks latency, result, optional hold, handshake.
  task automatic collect(input string name, input int hold);
    int   lat;
    exp_t e;
    exp_t got;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (out_valid !== 1'b1 && lat < 20);
    tests_run++;
    if (lat != 4 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_latency: got %0d edges (out_valid=%b) required 4", name, lat, out_valid);
    end
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $display("FAIL %s_scoreboard: empty queue, result unexpected", name);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    got = '{s: sum, c: cout, o: ovf};
    tests_run++;
    if (got !== e) begin
      tests_failed++;
      $display("FAIL %s_result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, e.s, e.c, e.o);
    end
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      tests_run++;
      if (sum !== e.s || cout !== e.c || ovf !== e.o || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s_hold%0d: sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b required sum=%h cout=%b ovf=%b 0 1",
                 name, k, sum, cout, ovf, in_ready, out_valid, e.s, e.c, e.o);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_release: in_ready=%b out_valid=%b required 1 0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First rising edge after release must already accept.
    drive_accept(16'h1234, 16'h0001, 1'b0);
    collect("first_after_reset", 0);
  endtask

  task automatic test_basic();
    drive_accept(16'h1234, 16'h0001, 1'b0);
    collect("basic", 0);
    drive_accept(16'h00A5, 16'h5A5A, 1'b1);
    collect("mixed", 0);
  endtask

  task automatic test_carry_chain();
    drive_accept(16'hFFFF, 16'h0001, 1'b0);
    collect("carry_chain", 0);
    drive_accept(16'hFFFF, 16'hFFFF, 1'b1);
    collect("all_ones", 0);
  endtask

  task automatic test_overflow();
    drive_accept(16'h7FFF, 16'h0000, 1'b1);
    collect("pos_ovf", 0);
    drive_accept(16'h8000, 16'h8000, 1'b0);
    collect("neg_ovf", 0);
    drive_accept(16'h8000, 16'h7FFF, 1'b1);
    collect("no_ovf_mixed_sign", 0);
  endtask

  task automatic test_hold();
    drive_accept(16'h1234, 16'h0001, 1'b0);
    collect("hold", 10);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL hold_no_extra: queue size %0d required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0 || cout !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: out_valid=%b in_ready=%b sum=%h cout=%b required 0 1 0000 0",
               out_valid, in_ready, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL midreset_abandon%0d: out_valid=%b in_ready=%b required 0 1", k, out_valid, in_ready);
      end
    end
    drive_accept(16'h0F0F, 16'h00F1, 1'b0);
    collect("after_midreset", 0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta[3];
    logic [15:0] tb_[3];
    logic        tc[3];
    int          n_acc, n_res, last_acc;
    logic        accepting;
    exp_t        e;
    ta[0] = 16'h0102; tb_[0] = 16'h0304; tc[0] = 1'b0;
    ta[1] = 16'h7FF0; tb_[1] = 16'h0010; tc[1] = 1'b0;
    ta[2] = 16'hFF00; tb_[2] = 16'h0100; tc[2] = 1'b1;
    n_acc = 0; n_res = 0; last_acc = 0;
    a = ta[0]; b = tb_[0]; cin = tc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && n_res < 3; c++) begin
      accepting = in_ready && in_valid;
      if (accepting) sb.push_back(model(a, b, cin));
      if (out_valid === 1'b1) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_scoreboard: result %h with empty queue", sum);
        end else begin
          e = sb.pop_front();
          if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
            tests_failed++;
            $display("FAIL b2b_result%0d: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                     n_res, sum, cout, ovf, e.s, e.c, e.o);
          end
        end
        n_res++;
      end
      @(posedge clk); #1;
      if (accepting) begin
        if (n_acc > 0) begin
          tests_run++;
          if (c + 1 - last_acc != 6) begin
            tests_failed++;
            $display("FAIL b2b_interval%0d: %0d cycles required 6", n_acc, c + 1 - last_acc);
          end
        end
        last_acc = c + 1;
        n_acc++;
        if (n_acc < 3) begin
          a = ta[n_acc]; b = tb_[n_acc]; cin = tc[n_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests_run++;
    if (n_res != 3 || n_acc != 3) begin
      tests_failed++;
      $display("FAIL b2b_count: accepts=%0d results=%0d required 3 3", n_acc, n_res);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
